// File: rtl/port_arbiter.sv
// Round-robin arbiter: one pending descriptor slot per port, issued one at a time to the copy engine.
// Optional per-port grant counters (output o_grant_cnt) are enabled by defining PORT_ARB_STAT_EN.
module port_arbiter #(
    parameter int pFIFO_WIDTH = 11,
    parameter int pDEPTH_RAM  = 2048,
    parameter int pPORTS      = 4
) (
    input  logic                                  iclk,
    input  logic                                  i_rst_n,
    input  logic [pPORTS-1:0]                     i_request,
    input  logic [pPORTS*pFIFO_WIDTH-1:0]         i_length,
    input  logic [pPORTS*$clog2(pDEPTH_RAM)-1:0]  i_start_adress,
    input  logic                                  i_ready,
    input  logic                                  i_done,
    output logic                                  o_valid,
    output logic [pFIFO_WIDTH-1:0]                o_length,
    output logic [$clog2(pDEPTH_RAM)-1:0]         o_start_adress,
    output logic [$clog2(pPORTS)-1:0]             o_port_num,
    output logic                                  o_busy,
    output logic [pPORTS-1:0]                     o_overflow
`ifdef PORT_ARB_STAT_EN
    ,
    output logic [pPORTS*16-1:0]                  o_grant_cnt
`endif
);

    localparam int AW = $clog2(pDEPTH_RAM);
    localparam int PW = $clog2(pPORTS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [pPORTS-1:0]      pend_q, pend_d;
    logic [pFIFO_WIDTH-1:0] slot_len_q  [pPORTS];
    logic [pFIFO_WIDTH-1:0] slot_len_d  [pPORTS];
    logic [AW-1:0]          slot_addr_q [pPORTS];
    logic [AW-1:0]          slot_addr_d [pPORTS];
    logic [pPORTS-1:0]      ovf_q, ovf_d;
    logic [PW-1:0]          last_q, last_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic [pFIFO_WIDTH-1:0] len_q, len_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [PW-1:0]          port_q, port_d;

    logic                   found_s;
    logic                   grant_s;
    logic [PW-1:0]          win_s;
    logic [PW-1:0]          idx_s;
    logic [pPORTS-1:0]      clear_s;

`ifdef PORT_ARB_STAT_EN
    logic [15:0]            cnt_q [pPORTS];
    logic [15:0]            cnt_d [pPORTS];
`endif

    // Round-robin search starting just after the last granted port.
    always_comb begin
        found_s = 1'b0;
        win_s   = {PW{1'b0}};
        idx_s   = {PW{1'b0}};
        for (int i = 1; i <= pPORTS; i++) begin
            idx_s = PW'((int'(last_q) + i) % pPORTS);
            if (!found_s && pend_q[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
        grant_s = (state_q == ST_IDLE) && found_s;
        clear_s = {pPORTS{1'b0}};
        if (grant_s) begin
            clear_s[win_s] = 1'b1;
        end else begin
            clear_s = {pPORTS{1'b0}};
        end
    end

    // Slot capture, overflow detection and the issue/busy handshake sequencing.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        slot_len_d  = slot_len_q;
        slot_addr_d = slot_addr_q;
        ovf_d       = ovf_q;
        last_d      = last_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        len_d       = len_q;
        addr_d      = addr_q;
        port_d      = port_q;

        // A slot being granted this cycle is free to accept a same-cycle request.
        for (int k = 0; k < pPORTS; k++) begin
            if (i_request[k]) begin
                if (pend_q[k] && !clear_s[k]) begin
                    ovf_d[k]  = 1'b1;
                    pend_d[k] = 1'b1;
                end else begin
                    pend_d[k]      = 1'b1;
                    slot_len_d[k]  = i_length[k*pFIFO_WIDTH +: pFIFO_WIDTH];
                    slot_addr_d[k] = i_start_adress[k*AW +: AW];
                end
            end else if (clear_s[k]) begin
                pend_d[k] = 1'b0;
            end else begin
                pend_d[k] = pend_q[k];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    len_d   = slot_len_q[win_s];
                    addr_d  = slot_addr_q[win_s];
                    port_d  = win_s;
                    last_d  = win_s;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_BUSY: begin
                if (i_done) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef PORT_ARB_STAT_EN
    // Saturating per-port grant counters.
    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < pPORTS; k++) begin
            if (clear_s[k] && (cnt_q[k] != 16'hFFFF)) begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end else begin
                cnt_d[k] = cnt_q[k];
            end
        end
    end

    for (genvar g = 0; g < pPORTS; g++) begin : g_cnt_out
        assign o_grant_cnt[g*16 +: 16] = cnt_q[g];
    end
`endif

    // State register for slots, pointer, FSM and registered outputs.
    always_ff @(posedge iclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= {pPORTS{1'b0}};
            ovf_q   <= {pPORTS{1'b0}};
            last_q  <= PW'(pPORTS - 1);
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            len_q   <= {pFIFO_WIDTH{1'b0}};
            addr_q  <= {AW{1'b0}};
            port_q  <= {PW{1'b0}};
            for (int k = 0; k < pPORTS; k++) begin
                slot_len_q[k]  <= {pFIFO_WIDTH{1'b0}};
                slot_addr_q[k] <= {AW{1'b0}};
`ifdef PORT_ARB_STAT_EN
                cnt_q[k]       <= 16'd0;
`endif
            end
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            port_q      <= port_d;
            slot_len_q  <= slot_len_d;
            slot_addr_q <= slot_addr_d;
`ifdef PORT_ARB_STAT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign o_valid        = valid_q;
    assign o_busy         = busy_q;
    assign o_length       = len_q;
    assign o_start_adress = addr_q;
    assign o_port_num     = port_q;
    assign o_overflow     = ovf_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Self-checking bench for port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_port_arbiter;

    localparam int FW = 11;
    localparam int AW = 11;
    localparam int NP = 4;
    localparam int PW = 2;

    logic               iclk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic [NP-1:0]      i_request = '0;
    logic [NP*FW-1:0]   i_length = '0;
    logic [NP*AW-1:0]   i_start_adress = '0;
    logic               i_ready = 1'b0;
    logic               i_done = 1'b0;
    logic               o_valid;
    logic [FW-1:0]      o_length;
    logic [AW-1:0]      o_start_adress;
    logic [PW-1:0]      o_port_num;
    logic               o_busy;
    logic [NP-1:0]      o_overflow;
`ifdef PORT_ARB_STAT_EN
    logic [NP*16-1:0]   o_grant_cnt;
`endif

    port_arbiter #(.pFIFO_WIDTH(FW), .pDEPTH_RAM(2048), .pPORTS(NP)) dut (
        .iclk           (iclk),
        .i_rst_n        (i_rst_n),
        .i_request      (i_request),
        .i_length       (i_length),
        .i_start_adress (i_start_adress),
        .i_ready        (i_ready),
        .i_done         (i_done),
        .o_valid        (o_valid),
        .o_length       (o_length),
        .o_start_adress (o_start_adress),
        .o_port_num     (o_port_num),
        .o_busy         (o_busy),
        .o_overflow     (o_overflow)
`ifdef PORT_ARB_STAT_EN
        ,
        .o_grant_cnt    (o_grant_cnt)
`endif
    );

    always #5 iclk = ~iclk;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: pending slots, sticky drops, pointer and handshake phase.
    bit          m_pend [NP];
    int          m_len  [NP];
    int          m_addr [NP];
    bit [NP-1:0] m_ovf;
    int          m_last;
    int          m_phase;   // 0 waiting to grant, 1 offered, 2 copy in flight
    bit          e_valid, e_busy;
    int          e_len, e_addr, e_port;

    int          got[$];    // ports observed on each new o_valid
    bit          seen_valid;

    task automatic model_reset();
        for (int k = 0; k < NP; k++) begin
            m_pend[k] = 1'b0;
            m_len[k]  = 0;
            m_addr[k] = 0;
        end
        m_ovf   = '0;
        m_last  = NP - 1;
        m_phase = 0;
        e_valid = 1'b0;
        e_busy  = 1'b0;
        e_len   = 0;
        e_addr  = 0;
        e_port  = 0;
        seen_valid = 1'b0;
    endtask

    task automatic model_edge(input logic [NP-1:0] rq, input logic rdy, input logic dn);
        bit found;
        int win;
        found = 1'b0;
        win   = 0;
        if (m_phase == 0) begin
            for (int s = 1; s <= NP; s++) begin
                int p;
                p = (m_last + s) % NP;
                if (!found && m_pend[p]) begin
                    found = 1'b1;
                    win   = p;
                end
            end
        end
        if (found) begin
            e_len  = m_len[win];
            e_addr = m_addr[win];
            e_port = win;
            m_last = win;
            m_pend[win] = 1'b0;
        end
        for (int k = 0; k < NP; k++) begin
            if (rq[k]) begin
                if (m_pend[k]) m_ovf[k] = 1'b1;
                else begin
                    m_pend[k] = 1'b1;
                    m_len[k]  = int'(i_length[k*FW +: FW]);
                    m_addr[k] = int'(i_start_adress[k*AW +: AW]);
                end
            end
        end
        case (m_phase)
            0: if (found) begin e_valid = 1'b1; e_busy = 1'b1; m_phase = 1; end
            1: if (rdy)   begin e_valid = 1'b0; m_phase = 2; end
            default: if (dn) begin e_busy = 1'b0; m_phase = 0; end
        endcase
    endtask

    task automatic set_port(input int k, input int len, input int addr);
        i_length[k*FW +: FW]       = FW'(len);
        i_start_adress[k*AW +: AW] = AW'(addr);
    endtask

    // One clock: drive inputs, advance the model at the edge, sample 1 time unit later.
    task automatic cycle(input logic [NP-1:0] rq, input logic rdy, input logic dn);
        i_request = rq;
        i_ready   = rdy;
        i_done    = dn;
        @(posedge iclk);
        model_edge(rq, rdy, dn);
        #1;
        i_request = '0;
        i_ready   = 1'b0;
        i_done    = 1'b0;
        if (o_valid && !seen_valid) got.push_back(int'(o_port_num));
        seen_valid = o_valid;
    endtask

    task automatic apply_reset();
        @(negedge iclk);
        i_rst_n = 1'b0;
        i_request = '0;
        i_ready = 1'b0;
        i_done = 1'b0;
        @(negedge iclk);
        i_rst_n = 1'b1;
        model_reset();
        got.delete();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({o_valid, o_busy, o_length, o_start_adress, o_port_num, o_overflow} !== '0)
            begin errors++; $display("FAIL reset_state: got v=%b b=%b len=%0d addr=%0h port=%0d ovf=%b, want all 0",
                o_valid, o_busy, o_length, o_start_adress, o_port_num, o_overflow); end
        @(negedge iclk);
        i_rst_n = 1'b1;
        model_reset();
        set_port(0, 7, 'h11);
        set_port(1, 9, 'h22);
        cycle(4'b0011, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);
        checks++;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", o_valid); end
        #3;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_busy, o_length, o_start_adress, o_port_num, o_overflow} !== '0)
            begin errors++; $display("FAIL async_reset: got v=%b b=%b len=%0d addr=%0h port=%0d, want all 0",
                o_valid, o_busy, o_length, o_start_adress, o_port_num); end
        @(negedge iclk);
        i_rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0000, 1'b1, 1'b1);
            checks++;
            if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_discard cyc %0d: got valid %b want 0", i, o_valid); end
        end
        set_port(2, 64, 'h100);
        cycle(4'b0100, 1'b0, 1'b0);
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got valid %b want 0", o_valid); end
        cycle(4'b0000, 1'b0, 1'b0);
        checks++;
        if ({o_valid, o_busy, o_port_num, o_length, o_start_adress} !== {1'b1, 1'b1, 2'd2, 11'd64, 11'h100})
            begin errors++; $display("FAIL first_grant: got v=%b b=%b port=%0d len=%0d addr=%0h, want v=1 b=1 port=2 len=64 addr=100",
                o_valid, o_busy, o_port_num, o_length, o_start_adress); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            cycle(4'b0000, 1'b0, 1'b1);
            checks++;
            if ({o_valid, o_busy, o_port_num, o_length, o_start_adress} !== {1'b1, 1'b1, 2'd2, 11'd64, 11'h100})
                begin errors++; $display("FAIL hold cyc %0d: got v=%b b=%b port=%0d len=%0d addr=%0h, want 1 1 2 64 100",
                    i, o_valid, o_busy, o_port_num, o_length, o_start_adress); end
        end
        cycle(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({o_valid, o_busy, o_length} !== {1'b0, 1'b1, 11'd64})
                begin errors++; $display("FAIL in_flight cyc %0d: got v=%b b=%b len=%0d, want v=0 b=1 len=64", i, o_valid, o_busy, o_length); end
            cycle(4'b0000, 1'b0, 1'b0);
        end
        cycle(4'b0000, 1'b0, 1'b1);
        checks++;
        if ({o_valid, o_busy} !== 2'b00) begin errors++; $display("FAIL done_release: got v=%b b=%b want 0 0", o_valid, o_busy); end
    endtask

    task automatic test_round_robin();
        int exp_a[4] = '{0, 1, 2, 3};
        int exp_b[2] = '{1, 3};
        int exp_c[2] = '{3, 0};
        int n;
        apply_reset();
        for (int k = 0; k < NP; k++) set_port(k, 10 + k, 'h10 * (k + 1));
        cycle(4'b1111, 1'b1, 1'b1);
        n = 0;
        while (got.size() < 4 && n < 40) begin cycle(4'b0000, 1'b1, 1'b1); n++; end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_a[i])
                begin errors++; $display("FAIL rr_all grant %0d: got %0d want %0d", i, (i < got.size()) ? got[i] : -1, exp_a[i]); end
        end
        got.delete();
        set_port(1, 111, 'h1A);
        set_port(3, 333, 'h3A);
        cycle(4'b1010, 1'b1, 1'b1);
        n = 0;
        while (got.size() < 2 && n < 40) begin cycle(4'b0000, 1'b1, 1'b1); n++; end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_b[i])
                begin errors++; $display("FAIL rr_13 grant %0d: got %0d want %0d", i, (i < got.size()) ? got[i] : -1, exp_b[i]); end
        end
        for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, 1'b1);
        got.delete();
        cycle(4'b0010, 1'b1, 1'b1);
        cycle(4'b1001, 1'b1, 1'b1);
        checks++;
        if ({o_valid, o_port_num} !== {1'b1, 2'd1}) begin errors++; $display("FAIL rr_solo: got v=%b port=%0d want v=1 port=1", o_valid, o_port_num); end
        got.delete();
        n = 0;
        while (got.size() < 2 && n < 40) begin cycle(4'b0000, 1'b1, 1'b1); n++; end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_c[i])
                begin errors++; $display("FAIL rr_wrap grant %0d: got %0d want %0d", i, (i < got.size()) ? got[i] : -1, exp_c[i]); end
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        set_port(0, 10, 'h20);
        cycle(4'b0001, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        set_port(1, 100, 'h30);
        cycle(4'b0010, 1'b0, 1'b0);
        checks++;
        if (o_overflow !== 4'b0000) begin errors++; $display("FAIL ovf_first: got %b want 0000", o_overflow); end
        set_port(1, 200, 'h40);
        cycle(4'b0010, 1'b0, 1'b0);
        checks++;
        if (o_overflow !== 4'b0010) begin errors++; $display("FAIL ovf_set: got %b want 0010", o_overflow); end
        cycle(4'b0000, 1'b0, 1'b1);
        got.delete();
        cycle(4'b0000, 1'b0, 1'b0);
        checks++;
        if ({o_valid, o_port_num, o_length, o_start_adress} !== {1'b1, 2'd1, 11'd100, 11'h30})
            begin errors++; $display("FAIL ovf_kept: got v=%b port=%0d len=%0d addr=%0h want 1 1 100 30",
                o_valid, o_port_num, o_length, o_start_adress); end
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(4'b0000, 1'b1, 1'b1);
        checks++;
        if (got.size() !== 1) begin errors++; $display("FAIL ovf_lost: got %0d grants want 1", got.size()); end
        checks++;
        if (o_overflow !== 4'b0010) begin errors++; $display("FAIL ovf_sticky: got %b want 0010", o_overflow); end
    endtask

    task automatic test_same_cycle_reload();
        apply_reset();
        set_port(0, 5, 'h50);
        cycle(4'b0001, 1'b0, 1'b0);
        set_port(0, 6, 'h60);
        cycle(4'b0001, 1'b0, 1'b0);
        checks++;
        if ({o_valid, o_port_num, o_length, o_start_adress, o_overflow} !== {1'b1, 2'd0, 11'd5, 11'h50, 4'b0000})
            begin errors++; $display("FAIL reload_grant1: got v=%b port=%0d len=%0d addr=%0h ovf=%b want 1 0 5 50 0000",
                o_valid, o_port_num, o_length, o_start_adress, o_overflow); end
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b0);
        checks++;
        if ({o_valid, o_port_num, o_length, o_start_adress, o_overflow} !== {1'b1, 2'd0, 11'd6, 11'h60, 4'b0000})
            begin errors++; $display("FAIL reload_grant2: got v=%b port=%0d len=%0d addr=%0h ovf=%b want 1 0 6 60 0000",
                o_valid, o_port_num, o_length, o_start_adress, o_overflow); end
    endtask

    task automatic test_random();
        logic [NP-1:0] rq;
        int bad;
        apply_reset();
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NP; k++) begin
                rq[k] = ($urandom_range(5, 0) == 0);
                set_port(k, (c % 50 == 0) ? 0 : int'($urandom_range(2047, 0)), int'($urandom_range(2047, 0)));
            end
            cycle(rq, logic'($urandom_range(1, 0)), logic'($urandom_range(2, 0) == 0));
            checks++;
            if ({o_valid, o_busy, o_length, o_start_adress, o_port_num, o_overflow} !==
                {e_valid, e_busy, FW'(e_len), AW'(e_addr), PW'(e_port), m_ovf}) begin
                errors++;
                if (bad < 10) $display("FAIL random cyc %0d: got v=%b b=%b len=%0d addr=%0h port=%0d ovf=%b want v=%b b=%b len=%0d addr=%0h port=%0d ovf=%b",
                    c, o_valid, o_busy, o_length, o_start_adress, o_port_num, o_overflow,
                    e_valid, e_busy, e_len, e_addr, e_port, m_ovf);
                bad++;
            end
        end
        checks++;
        if (got.size() < 20) begin errors++; $display("FAIL random_activity: got %0d grants want at least 20", got.size()); end
    endtask

`ifdef PORT_ARB_STAT_EN
    task automatic test_stat();
        apply_reset();
        for (int g = 0; g < 5; g++) begin
            set_port(3, 40 + g, 'h70 + g);
            cycle(4'b1000, 1'b1, 1'b1);
            for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, 1'b1);
        end
        checks++;
        if (o_grant_cnt !== {16'd5, 16'd0, 16'd0, 16'd0})
            begin errors++; $display("FAIL grant_cnt: got %h want 0005000000000000", o_grant_cnt); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_backpressure();
        test_round_robin();
        test_overflow();
        test_same_cycle_reload();
        test_random();
`ifdef PORT_ARB_STAT_EN
        test_stat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within 500000 time units");
        $fatal(1, "timeout");
    end

endmodule
